// File: rtl/mem_stage_hs.sv
// Memory stage with a request/acknowledge data-memory handshake, a bounded ACK wait,
// and the write-back register that receives the stage result.
module mem_stage_hs #(
    parameter int XLEN  = 64,
    parameter int CST_W = 17,
    parameter int TMO   = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_V,
    input  logic [31:0]       MEM_IR,
    input  logic [CST_W-1:0]  MEM_Cst,
    input  logic [XLEN-1:0]   MEM_RES,
    input  logic [XLEN-1:0]   MEM_Address,
    input  logic [XLEN-1:0]   MEM_NPC,
    input  logic [XLEN-1:0]   MEM_Target_Address,
    input  logic              MEM_PC_MUX,
    output logic              DM_REQ,
    output logic              DM_WE,
    output logic [XLEN-1:0]   DM_ADDR,
    output logic [XLEN/8-1:0] DM_BE,
    output logic [XLEN-1:0]   DM_WDATA,
    input  logic              DM_ACK,
    input  logic [XLEN-1:0]   DM_RDATA,
    output logic              MEM_STALL,
    output logic              V_MEM_FE_BR_STALL,
    output logic [4:0]        MEM_DR,
    output logic              WB_V,
    output logic [CST_W-1:0]  WB_Cst,
    output logic [XLEN-1:0]   WB_RES,
    output logic              WB_PC_MUX,
    output logic [XLEN-1:0]   WB_NPC,
    output logic [31:0]       WB_IR,
    output logic [XLEN-1:0]   WB_Target_Address,
    output logic [1:0]        WB_EXC
);
    localparam int          BEW   = XLEN / 8;
    localparam int          OFFW  = $clog2(BEW);
    localparam logic [15:0] TMO_C = 16'(TMO);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, nxt_state;
    logic [15:0]     cnt, nxt_cnt;
    logic            acc, misal, tmo_hit, timeout_exit, ack;
    logic [1:0]      size;
    logic [OFFW-1:0] off, align_mask;
    logic [BEW-1:0]  be_base;
    logic [XLEN-1:0] rd_sh, ld_mask, ld_val;
    logic            sgn;
    logic [1:0]      exc_nxt;

    assign size = MEM_Cst[3:2];
    assign off  = MEM_Address[OFFW-1:0];
    assign acc  = MEM_V & MEM_Cst[6];

    always_comb begin
        align_mask = '0;
        be_base    = '0;
        ld_mask    = '1;
        sgn        = rd_sh[XLEN-1];
        case (size)
            2'd0: begin align_mask = '0;           be_base = BEW'(1);      ld_mask = XLEN'(64'hFF);        sgn = rd_sh[7];  end
            2'd1: begin align_mask = OFFW'(1);     be_base = BEW'(3);      ld_mask = XLEN'(64'hFFFF);      sgn = rd_sh[15]; end
            2'd2: begin align_mask = OFFW'(3);     be_base = BEW'(4'hF);   ld_mask = XLEN'(64'hFFFF_FFFF); sgn = rd_sh[31]; end
            default: begin align_mask = OFFW'(7);  be_base = BEW'(8'hFF);  ld_mask = '1;                   sgn = rd_sh[XLEN-1]; end
        endcase
    end

    // A doubleword on a 32-bit datapath is handled exactly like a misaligned access.
    assign misal    = (|(off & align_mask)) | (size == 2'd3 && XLEN == 32);
    assign DM_REQ   = acc & ~misal;
    assign DM_WE    = MEM_Cst[5];
    assign DM_ADDR  = {MEM_Address[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign DM_BE    = be_base << off;
    assign DM_WDATA = MEM_RES << {off, 3'b000};

    assign rd_sh  = DM_RDATA >> {off, 3'b000};
    assign ld_val = (rd_sh & ld_mask) | ((sgn & ~MEM_Cst[4]) ? ~ld_mask : '0);

    // ACK outranks the timeout, so a late ACK in the final cycle still completes normally.
    assign ack          = DM_REQ & DM_ACK;
    assign tmo_hit      = (state == WAIT) && (cnt == TMO_C);
    assign timeout_exit = DM_REQ & tmo_hit & ~DM_ACK;
    assign MEM_STALL    = DM_REQ & ~DM_ACK & ~tmo_hit;

    assign exc_nxt = (acc & misal) ? 2'd1 : (timeout_exit ? 2'd2 : 2'd0);

    assign V_MEM_FE_BR_STALL = MEM_V & ((MEM_IR[6:2] == 5'b11000) |
                                        (MEM_IR[6:2] == 5'b11001) |
                                        (MEM_IR[6:2] == 5'b11011));
    assign MEM_DR = MEM_IR[11:7];

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            IDLE: if (DM_REQ && !DM_ACK) begin
                nxt_state = WAIT;
                nxt_cnt   = 16'd1;
            end
            WAIT: if (DM_ACK || tmo_hit || !DM_REQ) begin
                nxt_state = IDLE;
                nxt_cnt   = 16'd0;
            end else begin
                nxt_cnt   = cnt + 16'd1;
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    // On a stall only the valid bit drops; everything else keeps the last capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WB_V      <= 1'b0;
            WB_EXC    <= 2'd0;
            WB_RES    <= '0;
            WB_PC_MUX <= 1'b0;
        end else if (MEM_STALL) begin
            WB_V <= 1'b0;
        end else begin
            WB_V              <= MEM_V;
            WB_Cst            <= MEM_Cst;
            WB_IR             <= MEM_IR;
            WB_NPC            <= MEM_NPC;
            WB_PC_MUX         <= MEM_PC_MUX;
            WB_Target_Address <= MEM_Target_Address;
            WB_EXC            <= exc_nxt;
            if (MEM_Cst[1] && ack)
                WB_RES <= ld_val;
            else if (exc_nxt != 2'd0)
                WB_RES <= '0;
            else
                WB_RES <= MEM_RES;
        end
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (XLEN=64, TMO=4): write-back results go through a
// scoreboard queue; handshake outputs are checked at each step.
module tb_mem_stage_hs;
    localparam int XLEN = 64;
    localparam int CST_W = 17;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              MEM_V;
    logic [31:0]       MEM_IR;
    logic [CST_W-1:0]  MEM_Cst;
    logic [XLEN-1:0]   MEM_RES, MEM_Address, MEM_NPC, MEM_Target_Address;
    logic              MEM_PC_MUX;
    logic              DM_REQ, DM_WE, DM_ACK;
    logic [XLEN-1:0]   DM_ADDR, DM_WDATA, DM_RDATA;
    logic [XLEN/8-1:0] DM_BE;
    logic              MEM_STALL, V_MEM_FE_BR_STALL;
    logic [4:0]        MEM_DR;
    logic              WB_V, WB_PC_MUX;
    logic [CST_W-1:0]  WB_Cst;
    logic [XLEN-1:0]   WB_RES, WB_NPC, WB_Target_Address;
    logic [31:0]       WB_IR;
    logic [1:0]        WB_EXC;

    mem_stage_hs #(.XLEN(XLEN), .CST_W(CST_W), .TMO(4)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_Cst(MEM_Cst),
        .MEM_RES(MEM_RES), .MEM_Address(MEM_Address), .MEM_NPC(MEM_NPC),
        .MEM_Target_Address(MEM_Target_Address), .MEM_PC_MUX(MEM_PC_MUX),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_BE(DM_BE),
        .DM_WDATA(DM_WDATA), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
        .MEM_STALL(MEM_STALL), .V_MEM_FE_BR_STALL(V_MEM_FE_BR_STALL), .MEM_DR(MEM_DR),
        .WB_V(WB_V), .WB_Cst(WB_Cst), .WB_RES(WB_RES), .WB_PC_MUX(WB_PC_MUX),
        .WB_NPC(WB_NPC), .WB_IR(WB_IR), .WB_Target_Address(WB_Target_Address),
        .WB_EXC(WB_EXC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] res;
        logic [1:0]  exc;
        logic [31:0] ir;
        logic [63:0] npc;
        logic [63:0] ta;
        logic [16:0] cst;
        logic        pcm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] mk_cst(bit acc, bit rw, bit uns, bit [1:0] sz, bit rm);
        logic [16:0] c;
        c = '0;
        c[6] = acc; c[5] = rw; c[4] = uns; c[3:2] = sz; c[1] = rm;
        return c;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ir, input logic [16:0] cst,
                         input logic [63:0] res, input logic [63:0] addr,
                         input logic ack, input logic [63:0] rdata);
        MEM_V = v; MEM_IR = ir; MEM_Cst = cst; MEM_RES = res; MEM_Address = addr;
        MEM_NPC = {32'h0, ir} + 64'd4;
        MEM_Target_Address = addr ^ 64'h5A5A;
        DM_ACK = ack; DM_RDATA = rdata;
        #1;
    endtask

    // Expectation for whatever is currently on the stage inputs.
    task automatic push(input logic [63:0] res, input logic [1:0] exc);
        exp_t e;
        e.res = res; e.exc = exc; e.ir = MEM_IR; e.npc = MEM_NPC;
        e.ta = MEM_Target_Address; e.cst = MEM_Cst; e.pcm = MEM_PC_MUX;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge CLK);
        #1;
        if (WB_V === 1'b1) begin
            chk("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_res", WB_RES, e.res);
                chk("wb_exc", 64'(WB_EXC), 64'(e.exc));
                chk("wb_ir", 64'(WB_IR), 64'(e.ir));
                chk("wb_npc", WB_NPC, e.npc);
                chk("wb_ta", WB_Target_Address, e.ta);
                chk("wb_cst", 64'(WB_Cst), 64'(e.cst));
                chk("wb_pcmux", 64'(WB_PC_MUX), 64'(e.pcm));
            end
        end
    endtask

    // Load that never gets an ACK: four stalled cycles, then a timeout capture.
    task automatic run_timeout(input logic [31:0] ir, input logic [63:0] addr);
        drive(1'b1, ir, mk_cst(1, 0, 0, 2'd2, 1), 64'h1234, addr, 1'b0, 64'hDEAD);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tmo_stall%0d", i), 64'(MEM_STALL), 64'd1);
            cyc();
            chk($sformatf("tmo_wbv%0d", i), 64'(WB_V), 64'd0);
        end
        chk("tmo_release", 64'(MEM_STALL), 64'd0);
        chk("tmo_req_held", 64'(DM_REQ), 64'd1);
        push(64'd0, 2'd2);
        cyc();
    endtask

    initial begin
        RESET = 1'b1;
        MEM_PC_MUX = 1'b0;
        drive(1'b0, 32'h0, 17'h0, 64'h0, 64'h0, 1'b0, 64'h0);
        cyc(); cyc();
        chk("rst_wbv", 64'(WB_V), 64'd0);
        chk("rst_exc", 64'(WB_EXC), 64'd0);
        chk("rst_res", WB_RES, 64'd0);
        chk("rst_pcmux", 64'(WB_PC_MUX), 64'd0);
        RESET = 1'b0;

        // LB 0x1003, same-cycle ACK, sign-extended byte
        drive(1'b1, 32'h0000_0283, mk_cst(1, 0, 0, 2'd0, 1), 64'h0, 64'h1003, 1'b1, 64'h0000_0000_8000_0000);
        chk("lb_req", 64'(DM_REQ), 64'd1);
        chk("lb_stall", 64'(MEM_STALL), 64'd0);
        chk("lb_be", 64'(DM_BE), 64'h08);
        chk("lb_addr", DM_ADDR, 64'h1000);
        push(64'hFFFF_FFFF_FFFF_FF80, 2'd0);
        cyc();

        // SH 0x1006, store data positioned in the top halfword
        drive(1'b1, 32'h0000_1023, mk_cst(1, 1, 0, 2'd1, 0), 64'hBEEF, 64'h1006, 1'b1, 64'h0);
        chk("sh_be", 64'(DM_BE), 64'hC0);
        chk("sh_wdata", DM_WDATA, 64'hBEEF_0000_0000_0000);
        chk("sh_addr", DM_ADDR, 64'h1000);
        chk("sh_we", 64'(DM_WE), 64'd1);
        push(64'hBEEF, 2'd0);
        cyc();

        // LW 0x1002 misaligned; ACK present but must be ignored
        drive(1'b1, 32'h0000_2303, mk_cst(1, 0, 0, 2'd2, 1), 64'h77, 64'h1002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mis_req", 64'(DM_REQ), 64'd0);
        chk("mis_stall", 64'(MEM_STALL), 64'd0);
        push(64'd0, 2'd1);
        cyc();

        // LHU 0x1002, zero-extended
        drive(1'b1, 32'h0000_5383, mk_cst(1, 0, 1, 2'd1, 1), 64'h0, 64'h1002, 1'b1, 64'h0000_0000_ABCD_0000);
        chk("lhu_be", 64'(DM_BE), 64'h0C);
        push(64'h0000_0000_0000_ABCD, 2'd0);
        cyc();

        // LW 0x1004, sign-extended upper word
        drive(1'b1, 32'h0000_2403, mk_cst(1, 0, 0, 2'd2, 1), 64'h0, 64'h1004, 1'b1, 64'h8765_4321_0000_0000);
        chk("lw_be", 64'(DM_BE), 64'hF0);
        push(64'hFFFF_FFFF_8765_4321, 2'd0);
        cyc();

        // LD 0x1008, ACK withheld for three cycles
        drive(1'b1, 32'h0000_3483, mk_cst(1, 0, 0, 2'd3, 1), 64'h0, 64'h1008, 1'b0, 64'h0);
        chk("ld_be", 64'(DM_BE), 64'hFF);
        chk("ld_addr", DM_ADDR, 64'h1008);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ld_stall%0d", i), 64'(MEM_STALL), 64'd1);
            cyc();
            chk($sformatf("ld_wbv%0d", i), 64'(WB_V), 64'd0);
        end
        DM_ACK = 1'b1; DM_RDATA = 64'h1122_3344_5566_7788;
        #1;
        chk("ld_release", 64'(MEM_STALL), 64'd0);
        push(64'h1122_3344_5566_7788, 2'd0);
        cyc();

        // branch, non-memory: passes MEM_RES through
        MEM_PC_MUX = 1'b1;
        drive(1'b1, 32'h0000_0F63, 17'h0, 64'h42, 64'h1003, 1'b0, 64'h0);
        chk("br_stall", 64'(V_MEM_FE_BR_STALL), 64'd1);
        chk("br_dr", 64'(MEM_DR), 64'h1E);
        chk("br_req", 64'(DM_REQ), 64'd0);
        push(64'h42, 2'd0);
        cyc();
        MEM_PC_MUX = 1'b0;

        // reset during the second WAIT cycle abandons the load
        drive(1'b1, 32'h0000_2503, mk_cst(1, 0, 0, 2'd2, 1), 64'h0, 64'h2000, 1'b0, 64'h0);
        chk("rw_nobr", 64'(V_MEM_FE_BR_STALL), 64'd0);
        chk("rw_stall0", 64'(MEM_STALL), 64'd1);
        cyc();
        chk("rw_stall1", 64'(MEM_STALL), 64'd1);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        chk("rw_wbv", 64'(WB_V), 64'd0);
        chk("rw_exc", 64'(WB_EXC), 64'd0);
        chk("rw_res", WB_RES, 64'd0);
        chk("rw_pcmux", 64'(WB_PC_MUX), 64'd0);
        drive(1'b1, 32'h0000_0033, 17'h0, 64'h99, 64'h0, 1'b0, 64'h0);
        chk("rw_next_stall", 64'(MEM_STALL), 64'd0);
        push(64'h99, 2'd0);
        cyc();

        // timeout after a full TMO wait, then a fresh access from IDLE
        run_timeout(32'h0000_2583, 64'h2000);
        drive(1'b1, 32'h0000_4603, mk_cst(1, 0, 1, 2'd0, 1), 64'h0, 64'h2001, 1'b1, 64'h0000_0000_0000_F000);
        chk("post_tmo_stall", 64'(MEM_STALL), 64'd0);
        chk("lbu_be", 64'(DM_BE), 64'h02);
        push(64'hF0, 2'd0);
        cyc();

        // ACK arriving in the timeout cycle completes normally
        drive(1'b1, 32'h0000_2683, mk_cst(1, 0, 0, 2'd2, 1), 64'h0, 64'h3000, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("late_stall%0d", i), 64'(MEM_STALL), 64'd1);
            cyc();
        end
        DM_ACK = 1'b1; DM_RDATA = 64'h0000_0000_7FFF_FFFF;
        #1;
        chk("late_release", 64'(MEM_STALL), 64'd0);
        push(64'h7FFF_FFFF, 2'd0);
        cyc();

        drive(1'b0, 32'h0, 17'h0, 64'h0, 64'h0, 1'b0, 64'h0);
        cyc();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter XLEN, default 64, sets data and address width; legal values are 32 and 64.
REQ-002 Parameter CST_W, default 17, sets the control-store width.
REQ-003 Parameter TMO, default 255, is the maximum number of DM_ACK wait cycles before a bus error; legal range is 1..65535.
REQ-004 Reset and clock are decided: reset RESET, synchronous, active-high; clock CLK.
REQ-005 Ports (name, direction, width, meaning):
  CLK  in  1  clock
  RESET  in  1  synchronous active-high reset
  MEM_V  in  1  stage holds a valid instruction
  MEM_IR  in  32  instruction
  MEM_Cst  in  CST_W  control: [6] ACC (memory access), [5] R_W (1=store), [4:2] SIZE (bit4=1 unsigned load; [3:2] 0=B, 1=H, 2=W, 3=D), [1] RES_MUX (1=load result)
  MEM_RES  in  XLEN  ALU result / store data
  MEM_Address  in  XLEN  byte address
  MEM_NPC, MEM_Target_Address  in  XLEN  pass-through
  MEM_PC_MUX  in  1  pass-through
  DM_REQ  out  1  memory request
  DM_WE  out  1  write enable
  DM_ADDR  out  XLEN  address, aligned down to XLEN/8 bytes
  DM_BE  out  XLEN/8  byte enables
  DM_WDATA  out  XLEN  lane-positioned store data
  DM_ACK  in  1  request completes this cycle
  DM_RDATA  in  XLEN  read data, valid with DM_ACK
  MEM_STALL  out  1  upstream holds stage inputs
  V_MEM_FE_BR_STALL  out  1  branch/jump in stage
  MEM_DR  out  5  MEM_IR[11:7]
  WB_V, WB_Cst, WB_RES, WB_PC_MUX, WB_NPC, WB_IR, WB_Target_Address  out  registered stage outputs
  WB_EXC  out  2  0=none, 1=misaligned, 2=bus timeout

Function
REQ-006 Access condition: ACC = MEM_V and MEM_Cst[6].
REQ-007 Alignment: OFF = MEM_Address[log2(XLEN/8)-1:0]. An access is misaligned if OFF is not a multiple of 2^SIZE[3:2]. An access is illegal if SIZE[3:2]=3 and XLEN=32. Misaligned and illegal accesses are treated identically.
REQ-008 FSM states are IDLE and WAIT; reset state is IDLE. A 16-bit counter CNT resets to 0.
REQ-009 DM_REQ = ACC and aligned, in either state. DM_WE = R_W. DM_ADDR, DM_BE and DM_WDATA are combinational from the stage inputs.
REQ-010 Stores: DM_BE = ((1<<2^SIZE)-1) << OFF. DM_WDATA = MEM_RES << (8*OFF). Loads drive DM_BE with the same mask.
REQ-011 Transitions:
  IDLE to WAIT when DM_REQ and not DM_ACK, with CNT := 1.
  WAIT stays in WAIT while not DM_ACK and CNT < TMO, with CNT += 1.
  WAIT to IDLE on DM_ACK or on CNT = TMO; CNT := 0 on exit.
REQ-012 MEM_STALL = DM_REQ and not DM_ACK and not (state = WAIT and CNT = TMO). A stall is therefore zero-cycle when DM_ACK is present in the request cycle.
REQ-013 When MEM_STALL = 1, the WB register captures WB_V := 0, and all other WB_* hold their values.
REQ-014 When MEM_STALL = 0, the WB register captures:
  WB_V := MEM_V; WB_Cst, WB_IR, WB_NPC, WB_PC_MUX, WB_Target_Address := their MEM_* inputs.
  WB_EXC := 1 if ACC and misaligned; 2 on timeout exit; else 0.
REQ-015 WB_RES when MEM_STALL = 0:
  If RES_MUX and DM_ACK: DM_RDATA >> (8*OFF), truncated to 2^SIZE bytes, then sign-extended (SIZE[4]=0) or zero-extended (SIZE[4]=1) to XLEN.
  If WB_EXC is nonzero: 0.
  Otherwise: MEM_RES.
REQ-016 A misaligned access issues no DM_REQ and causes no stall.
REQ-017 A DM_ACK received in the timeout cycle is honoured as a normal completion with WB_EXC = 0.
REQ-018 V_MEM_FE_BR_STALL = MEM_V and MEM_IR[6:2] is one of 11000, 11001 or 11011.
REQ-019 MEM_DR = MEM_IR[11:7], combinational.
REQ-020 DM_ACK is ignored when DM_REQ = 0.

Reset
REQ-021 RESET takes priority over every other condition. On RESET: state := IDLE, CNT := 0, WB_V := 0, WB_EXC := 0, WB_RES := 0, WB_PC_MUX := 0. All other WB_* are unspecified.
REQ-022 RESET asserted during WAIT abandons the request. DM_REQ may remain asserted combinationally, but no write-back occurs for that instruction.

Verification
REQ-023 XLEN=64, LB at address 0x1003, DM_ACK in the same cycle, DM_RDATA=0x00000000_80000000 -> no stall; WB_RES=0xFFFFFFFF_FFFFFF80, WB_V=1.
REQ-024 SH at address 0x1006, MEM_RES=0xBEEF -> DM_BE=0xC0, DM_WDATA=0xBEEF000000000000, DM_ADDR=0x1000.
REQ-025 LW at address 0x1002 -> DM_REQ=0, MEM_STALL=0; WB_EXC=1, WB_RES=0.
REQ-026 LD with DM_ACK held low for 3 cycles, then high -> MEM_STALL high for 3 cycles; WB_V=0 for 3 captures, then WB_V=1 with the load data.
REQ-027 TMO=4, DM_ACK never asserted -> stall releases after 4 WAIT cycles; WB_EXC=2, state returns to IDLE.
REQ-028 RESET pulsed in the 2nd WAIT cycle -> WB_V=0, state=IDLE, CNT=0; the next non-memory instruction passes through with WB_EXC=0.
